// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, RV32I opcodes,
// ALU operation codes, register-file writeback selects and opcode classes.
package control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    typedef enum logic [3:0] {
        ULA_ADD    = 4'd0,
        ULA_SUB    = 4'd1,
        ULA_AND    = 4'd2,
        ULA_OR     = 4'd3,
        ULA_XOR    = 4'd4,
        ULA_SLL    = 4'd5,
        ULA_SRL    = 4'd6,
        ULA_SRA    = 4'd7,
        ULA_SLT    = 4'd8,
        ULA_SLTU   = 4'd9,
        ULA_PASS_B = 4'd10
    } ula_op_t;

    localparam logic [1:0] RF_SEL_MEM   = 2'd0;
    localparam logic [1:0] RF_SEL_ULA   = 2'd1;
    localparam logic [1:0] RF_SEL_PC4   = 2'd2;
    localparam logic [1:0] RF_SEL_PCIMM = 2'd3;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_OP      = 4'd1,
        CLS_OPIMM   = 4'd2,
        CLS_LOAD    = 4'd3,
        CLS_STORE   = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_LUI     = 4'd6,
        CLS_AUIPC   = 4'd7,
        CLS_JAL     = 4'd8,
        CLS_JALR    = 4'd9
    } opclass_t;

    function automatic opclass_t classify(input logic [6:0] op);
        opclass_t cls;
        case (op)
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_OPIMM:  cls = CLS_OPIMM;
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_STORE:  cls = CLS_STORE;
            OPC_OP:     cls = CLS_OP;
            OPC_LUI:    cls = CLS_LUI;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_JALR:   cls = CLS_JALR;
            OPC_JAL:    cls = CLS_JAL;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/ula_decoder.sv
// Combinational ALU-op decode from {opcode class, funct3, funct7_5}; zero latency.
// funct7_5 only selects SUB for R-type and SRA for R-type/SRAI.
module ula_decoder
    import control_pkg::*;
(
    input  logic [3:0] i_opclass,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic [3:0] o_ula_op
);

    opclass_t w_cls;
    ula_op_t  w_arith;
    ula_op_t  w_op;

    assign w_cls = opclass_t'(i_opclass);

    always_comb begin
        w_arith = ULA_ADD;
        case (i_funct3)
            3'd0: w_arith = (w_cls == CLS_OP && i_funct7_5) ? ULA_SUB : ULA_ADD;
            3'd1: w_arith = ULA_SLL;
            3'd2: w_arith = ULA_SLT;
            3'd3: w_arith = ULA_SLTU;
            3'd4: w_arith = ULA_XOR;
            3'd5: w_arith = i_funct7_5 ? ULA_SRA : ULA_SRL;
            3'd6: w_arith = ULA_OR;
            3'd7: w_arith = ULA_AND;
            default: w_arith = ULA_ADD;
        endcase
    end

    always_comb begin
        w_op = ULA_ADD;
        case (w_cls)
            CLS_OP, CLS_OPIMM:     w_op = w_arith;
            CLS_LOAD, CLS_STORE:   w_op = ULA_ADD;
            CLS_BRANCH:            w_op = ULA_SUB;
            CLS_LUI:               w_op = ULA_PASS_B;
            default:               w_op = ULA_ADD;
        endcase
    end

    assign o_ula_op = w_op;

endmodule

// File: rtl/control_unit.sv
// Multicycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) driving the datapath strobes.
// CONTROL_UNIT_ILLEGAL_TRAP_EN: unknown opcodes halt with sticky illegal; otherwise they run as a NOP.
module control_unit
    import control_pkg::*;
(
    input  logic       CLK,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       ula_zero,
    input  logic       ula_lt,
    input  logic       ula_ltu,
    output logic       load_ir,
    output logic       load_pc,
    output logic       WE_RF,
    output logic       WE_MEM,
    output logic       ULA_din2_sel,
    output logic [1:0] RF_din_sel,
    output logic       pc_next_sel,
    output logic       pc_adder_sel,
    output logic [3:0] ula_op,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_next;
    opclass_t   r_cls;
    logic [2:0] r_funct3;
    logic       r_funct7_5;

    opclass_t   w_dec_cls;
    logic [3:0] w_ula_op;
    logic       w_taken;

    logic       w_load_ir;
    logic       w_load_pc;
    logic       w_we_rf;
    logic       w_we_mem;
    logic       w_din2_sel;
    logic [1:0] w_rf_sel;
    logic       w_pc_next_sel;
    logic       w_pc_adder_sel;
    logic [3:0] w_ula_op_out;

    assign w_dec_cls = classify(opcode);

    ula_decoder u_ula_decoder (
        .i_opclass  (r_cls),
        .i_funct3   (r_funct3),
        .i_funct7_5 (r_funct7_5),
        .o_ula_op   (w_ula_op)
    );

    // Fields are captured once in DECODE so later states ignore IR changes.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_cls      <= CLS_ILLEGAL;
            r_funct3   <= 3'd0;
            r_funct7_5 <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_cls      <= w_dec_cls;
                r_funct3   <= funct3;
                r_funct7_5 <= funct7_5;
            end
        end
    end

    always_comb begin
        w_taken = 1'b0;
        case (r_funct3)
            F3_BEQ:  w_taken = ula_zero;
            F3_BNE:  w_taken = !ula_zero;
            F3_BLT:  w_taken = ula_lt;
            F3_BGE:  w_taken = !ula_lt;
            F3_BLTU: w_taken = ula_ltu;
            F3_BGEU: w_taken = !ula_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next         = r_state;
        w_load_ir      = 1'b0;
        w_load_pc      = 1'b0;
        w_we_rf        = 1'b0;
        w_we_mem       = 1'b0;
        w_din2_sel     = 1'b0;
        w_rf_sel       = RF_SEL_MEM;
        w_pc_next_sel  = 1'b0;
        w_pc_adder_sel = 1'b0;
        w_ula_op_out   = 4'd0;

        case (r_state)
            ST_FETCH: begin
                w_load_ir = 1'b1;
                w_next    = ST_DECODE;
            end

            ST_DECODE: begin
                if (w_dec_cls == CLS_ILLEGAL) begin
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
                    w_next = ST_HALT;
`else
                    w_next = ST_WB;
`endif
                end else begin
                    w_next = ST_EXEC;
                end
            end

            ST_EXEC: begin
                w_ula_op_out = w_ula_op;
                w_next       = ST_WB;
                case (r_cls)
                    CLS_OPIMM, CLS_LUI: w_din2_sel = 1'b1;
                    CLS_LOAD, CLS_STORE: begin
                        w_din2_sel = 1'b1;
                        w_next     = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        w_load_pc      = 1'b1;
                        w_pc_adder_sel = 1'b1;
                        w_pc_next_sel  = w_taken;
                        w_next         = ST_FETCH;
                    end
                    default: w_next = ST_WB;
                endcase
            end

            ST_MEM: begin
                if (r_cls == CLS_STORE) begin
                    w_we_mem  = 1'b1;
                    w_load_pc = 1'b1;
                    w_next    = ST_FETCH;
                end else begin
                    w_next = ST_WB;
                end
            end

            ST_WB: begin
                // An unknown opcode lands here as a NOP: advance PC, write nothing.
                w_we_rf   = (r_cls != CLS_ILLEGAL);
                w_load_pc = 1'b1;
                w_next    = ST_FETCH;
                case (r_cls)
                    CLS_OP: begin
                        w_rf_sel     = RF_SEL_ULA;
                        w_ula_op_out = w_ula_op;
                    end
                    CLS_OPIMM, CLS_LUI: begin
                        w_rf_sel     = RF_SEL_ULA;
                        w_din2_sel   = 1'b1;
                        w_ula_op_out = w_ula_op;
                    end
                    CLS_AUIPC: begin
                        w_rf_sel       = RF_SEL_PCIMM;
                        w_pc_adder_sel = 1'b1;
                    end
                    CLS_JAL: begin
                        w_rf_sel       = RF_SEL_PC4;
                        w_pc_adder_sel = 1'b1;
                        w_pc_next_sel  = 1'b1;
                    end
                    CLS_JALR: begin
                        w_rf_sel      = RF_SEL_PC4;
                        w_pc_next_sel = 1'b1;
                    end
                    default: w_rf_sel = RF_SEL_MEM;
                endcase
            end

            ST_HALT: begin
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
                w_next = ST_HALT;
`else
                w_next = ST_FETCH;
`endif
            end

            default: w_next = ST_FETCH;
        endcase
    end

    assign load_ir      = reset ? 1'b0 : w_load_ir;
    assign load_pc      = reset ? 1'b0 : w_load_pc;
    assign WE_RF        = reset ? 1'b0 : w_we_rf;
    assign WE_MEM       = reset ? 1'b0 : w_we_mem;
    assign ULA_din2_sel = reset ? 1'b0 : w_din2_sel;
    assign RF_din_sel   = reset ? 2'd0 : w_rf_sel;
    assign pc_next_sel  = reset ? 1'b0 : w_pc_next_sel;
    assign pc_adder_sel = reset ? 1'b0 : w_pc_adder_sel;
    assign ula_op       = reset ? 4'd0 : w_ula_op_out;

`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
    assign illegal = !reset && (r_state == ST_HALT);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected strobe sequences built from the ISA-level rules,
// compared every cycle; directed cases first, then randomized instructions and flags.
module tb_control_unit;
    import control_pkg::*;

    logic       CLK = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       ula_zero, ula_lt, ula_ltu;
    logic       load_ir, load_pc, WE_RF, WE_MEM, ULA_din2_sel;
    logic [1:0] RF_din_sel;
    logic       pc_next_sel, pc_adder_sel;
    logic [3:0] ula_op;
    logic       illegal;

    int checks = 0;
    int failures = 0;

    logic [13:0] exp_q[$];
    logic [13:0] act;

    always #5 CLK = ~CLK;

    control_unit dut (
        .CLK          (CLK),
        .reset        (reset),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .ula_zero     (ula_zero),
        .ula_lt       (ula_lt),
        .ula_ltu      (ula_ltu),
        .load_ir      (load_ir),
        .load_pc      (load_pc),
        .WE_RF        (WE_RF),
        .WE_MEM       (WE_MEM),
        .ULA_din2_sel (ULA_din2_sel),
        .RF_din_sel   (RF_din_sel),
        .pc_next_sel  (pc_next_sel),
        .pc_adder_sel (pc_adder_sel),
        .ula_op       (ula_op),
        .illegal      (illegal)
    );

    assign act = {load_ir, load_pc, WE_RF, WE_MEM, ULA_din2_sel, RF_din_sel,
                  pc_next_sel, pc_adder_sel, ula_op, illegal};

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] mk(input logic lir, input logic lpc, input logic werf,
                                       input logic wemem, input logic d2, input logic [1:0] rfs,
                                       input logic pns, input logic pas, input logic [3:0] u,
                                       input logic ill);
        return {lir, lpc, werf, wemem, d2, rfs, pns, pas, u, ill};
    endfunction

    // RV32I arithmetic by funct3; alternate form only for SUB (R-type) and SRA/SRAI.
    function automatic logic [3:0] alu(input logic [2:0] f3, input logic f75, input logic is_r);
        ula_op_t tbl [8];
        tbl = '{ULA_ADD, ULA_SLL, ULA_SLT, ULA_SLTU, ULA_XOR, ULA_SRL, ULA_OR, ULA_AND};
        if (f3 == 3'd0 && is_r && f75) return ULA_SUB;
        if (f3 == 3'd5 && f75) return ULA_SRA;
        return tbl[f3];
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic lt,
                                      input logic ltu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void build(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                                  input logic z, input logic lt, input logic ltu);
        logic [3:0] u;
        exp_q.delete();
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'd0, 0, 0, 4'd0, 0));
        exp_q.push_back(14'd0);
        case (op)
            7'h33: begin
                u = alu(f3, f75, 1'b1);
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 0, 0, u, 0));
                exp_q.push_back(mk(0, 1, 1, 0, 0, 2'd1, 0, 0, u, 0));
            end
            7'h13: begin
                u = alu(f3, f75, 1'b0);
                exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd0, 0, 0, u, 0));
                exp_q.push_back(mk(0, 1, 1, 0, 1, 2'd1, 0, 0, u, 0));
            end
            7'h03: begin
                exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd0, 0, 0, ULA_ADD, 0));
                exp_q.push_back(14'd0);
                exp_q.push_back(mk(0, 1, 1, 0, 0, 2'd0, 0, 0, 4'd0, 0));
            end
            7'h23: begin
                exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd0, 0, 0, ULA_ADD, 0));
                exp_q.push_back(mk(0, 1, 0, 1, 0, 2'd0, 0, 0, 4'd0, 0));
            end
            7'h63: exp_q.push_back(mk(0, 1, 0, 0, 0, 2'd0, br_taken(f3, z, lt, ltu), 1, ULA_SUB, 0));
            7'h37: begin
                exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd0, 0, 0, ULA_PASS_B, 0));
                exp_q.push_back(mk(0, 1, 1, 0, 1, 2'd1, 0, 0, ULA_PASS_B, 0));
            end
            7'h17: begin
                exp_q.push_back(14'd0);
                exp_q.push_back(mk(0, 1, 1, 0, 0, 2'd3, 0, 1, 4'd0, 0));
            end
            7'h6F: begin
                exp_q.push_back(14'd0);
                exp_q.push_back(mk(0, 1, 1, 0, 0, 2'd2, 1, 1, 4'd0, 0));
            end
            7'h67: begin
                exp_q.push_back(14'd0);
                exp_q.push_back(mk(0, 1, 1, 0, 0, 2'd2, 1, 0, 4'd0, 0));
            end
            default: begin
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
                for (int k = 0; k < 4; k++) exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 0, 0, 4'd0, 1));
`else
                exp_q.push_back(mk(0, 1, 0, 0, 0, 2'd0, 0, 0, 4'd0, 0));
`endif
            end
        endcase
    endfunction

    function automatic logic is_known(input logic [6:0] op);
        return op inside {7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
    endfunction

    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic f75, input logic z, input logic lt, input logic ltu);
        int npc;
        int want_npc;
        npc = 0;
        build(op, f3, f75, z, lt, ltu);
        opcode = op; funct3 = f3; funct7_5 = f75;
        ula_zero = z; ula_lt = lt; ula_ltu = ltu;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge CLK);
            chk($sformatf("%s[%0d]", tag, i), act, exp_q[i]);
            npc += int'(load_pc);
            @(posedge CLK);
            #1;
            if (i == 1) begin
                opcode = 7'($urandom); funct3 = 3'($urandom); funct7_5 = 1'($urandom);
            end
        end
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
        want_npc = is_known(op) ? 1 : 0;
`else
        want_npc = 1;
`endif
        chk({tag, "_load_pc_count"}, 14'(npc), 14'(want_npc));
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        @(negedge CLK);
        chk(tag, act, 14'd0);
        @(posedge CLK);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [6:0] ops [9];
        ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
        reset = 1'b1;
        opcode = 7'h33; funct3 = 3'd0; funct7_5 = 1'b0;
        ula_zero = 1'b0; ula_lt = 1'b0; ula_ltu = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk($sformatf("reset_outputs[%0d]", i), act, 14'd0);
            @(posedge CLK);
        end
        #1;
        reset = 1'b0;

        run_instr("add",  7'h33, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("sub",  7'h33, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_instr("lw",   7'h03, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("sw",   7'h23, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("beq_t", 7'h63, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_instr("beq_n", 7'h63, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        run_instr("bltu_t", 7'h63, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        run_instr("bltu_n", 7'h63, 3'd6, 1'b0, 1'b1, 1'b1, 1'b0);
        run_instr("jal",  7'h6F, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("jalr", 7'h67, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("auipc", 7'h17, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("lui",  7'h37, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("srai", 7'h13, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        run_instr("addi_f75", 7'h13, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        run_instr("unknown_7f", 7'h7F, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
        pulse_reset("halt_reset");
`endif

        // Reset landing in a load's EXEC cycle must abort without a register write.
        opcode = 7'h03; funct3 = 3'd2; funct7_5 = 1'b0;
        @(negedge CLK);
        chk("abort_fetch", act, mk(1, 0, 0, 0, 0, 2'd0, 0, 0, 4'd0, 0));
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("abort_decode", act, 14'd0);
        @(posedge CLK);
        #1;
        pulse_reset("abort_exec");
        run_instr("after_abort", 7'h33, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            op = ops[$urandom_range(0, 8)];
            run_instr($sformatf("rnd%0d_op%02h", n, op), op, 3'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
